// File: rtl/ram_tdp_param.sv
// True dual-port synchronous RAM: per-port enables with valid strobes, selectable
// same-port read-during-write, optional output register, collision flag and a clear sweep after reset.
module ram_tdp_param #(
  parameter int              DW        = 8,
  parameter int              AW        = 6,
  parameter int              RDW_MODE  = 0,
  parameter int              OUT_REG   = 0,
  parameter logic [DW-1:0]   CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] add_a,
  input  logic [DW-1:0] d_a,
  output logic [DW-1:0] q_a,
  output logic          valid_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] add_b,
  input  logic [DW-1:0] d_b,
  output logic [DW-1:0] q_b,
  output logic          valid_b,
  output logic          collision
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          acc_a, acc_b, wr_a, wr_b;
  logic [DW-1:0] r_a, r_b;
  logic          rv_a, rv_b;

  assign busy  = (state == CLEAR);
  assign acc_a = !rst && (state == READY) && en_a;
  assign acc_b = !rst && (state == READY) && en_b;
  assign wr_a  = acc_a && we_a;
  assign wr_b  = acc_b && we_b;

  // Sweep one word per cycle; the last word's write edge also enters READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (&clr_ptr) state <= READY;
    end
  end

  // NOTE: the storage array has no reset; the clear sweep initialises it, so it still maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) mem[clr_ptr] <= CLEAR_VAL;
    if (wr_b) mem[add_b] <= d_b;
    // NOTE: with non-blocking writes the later assignment wins, which gives port A priority on a tie.
    if (wr_a) mem[add_a] <= d_a;
  end

  // First read stage; reads see pre-edge contents, so cross-port readers always get old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      rv_a      <= 1'b0;
      rv_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      rv_a      <= acc_a;
      rv_b      <= acc_b;
      collision <= wr_a && wr_b && (add_a == add_b);
      if (acc_a) r_a <= (we_a && RDW_MODE == 0) ? d_a : mem[add_a];
      if (acc_b) r_b <= (we_b && RDW_MODE == 0) ? d_b : mem[add_b];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        q_a     <= '0;
        q_b     <= '0;
        valid_a <= 1'b0;
        valid_b <= 1'b0;
      end else begin
        valid_a <= rv_a;
        valid_b <= rv_b;
        if (rv_a) q_a <= r_a;
        if (rv_b) q_b <= r_b;
      end
    end
  end else begin : g_no_out_reg
    assign q_a     = r_a;
    assign q_b     = r_b;
    assign valid_a = rv_a;
    assign valid_b = rv_b;
  end

endmodule
